// File: rtl/overlay_pkg.sv
// Shared types for the overlay RAM arbiter: load sequencer states and default sizing.
package overlay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_READY   = 2'd3
    } ovl_state_t;

    localparam int OVL_FIFO_DEPTH = 4;

endpackage

// File: rtl/overlay_wr_fifo.sv
// Synchronous {addr,data} FIFO for download writes; push and pop may coincide.
// The caller only pushes when there is room (or a pop frees one) and only pops when non-empty.
module overlay_wr_fifo #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {push_addr, push_data};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign {head_addr, head_data} = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/overlay_ram_arbiter.sv
// Shares the single-port overlay RAM between HPS download writes and video scanout reads.
// Video reads always win; queued download writes drain in cycles without a video request.
module overlay_ram_arbiter
    import overlay_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = OVL_FIFO_DEPTH
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [DATA_W-1:0] dl_data,
    output logic              dl_wait,
    output logic              dl_overrun,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              copy_in_progress,
    output logic              overlay_ready,
    output ovl_state_t        state_dbg
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ovl_state_t        state;
    ovl_state_t        state_next;
    logic              dl_active_q;
    logic              dl_rise;
    logic              dl_fall;
    logic              rd_q;

    logic              push_req;
    logic              push;
    logic              pop;
    logic              drop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign dl_rise = dl_active & ~dl_active_q;
    assign dl_fall = ~dl_active & dl_active_q;

    // Download handshake: a byte is taken on any cycle with dl_wr high while LOADING and the
    // FIFO has room (a same-cycle drain counts as room); otherwise it is lost and dl_overrun
    // latches. dl_wait rises one entry early so a well-behaved HPS never hits that case.
    assign push_req = dl_wr & (state == ST_LOADING);
    assign pop      = ~vid_req & ~fifo_empty;
    assign push     = push_req & (~fifo_full | pop);
    assign drop     = push_req & fifo_full & ~pop;

    overlay_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk_sys),
        .rst_n     (reset_n),
        .push      (push),
        .push_addr (dl_addr),
        .push_data (dl_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_READY: if (dl_rise)    state_next = ST_LOADING;
            ST_LOADING:        if (dl_fall)    state_next = ST_FLUSH;
            ST_FLUSH:          if (fifo_empty) state_next = ST_READY;
            default:           state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            dl_active_q <= 1'b0;
            dl_overrun  <= 1'b0;
            rd_q        <= 1'b0;
            vid_valid   <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            dl_active_q <= dl_active;
            state       <= state_next;
            if (state != ST_LOADING && state_next == ST_LOADING) begin
                dl_overrun <= 1'b0;
            end else if (drop) begin
                dl_overrun <= 1'b1;
            end
            // Read data returns two cycles after the request; this tracks it.
            rd_q      <= vid_req;
            vid_valid <= rd_q;
            ram_we    <= pop;
            if (vid_req) begin
                ram_addr <= vid_addr;
            end else if (pop) begin
                ram_addr  <= head_addr;
                ram_wdata <= head_data;
            end
        end
    end

    assign dl_wait          = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
    assign vid_data         = ram_rdata;
    assign copy_in_progress = (state == ST_LOADING) || (state == ST_FLUSH);
    assign overlay_ready    = (state == ST_READY);
    assign state_dbg        = state;

endmodule

// File: tb/tb_overlay_ram_arbiter.sv
// Directed bench for overlay_ram_arbiter: cycle vector table plus hand-written load scenarios.
module tb_overlay_ram_arbiter;
    import overlay_pkg::*;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              dl_active;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [DATA_W-1:0] dl_data;
    logic              dl_wait;
    logic              dl_overrun;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              copy_in_progress;
    logic              overlay_ready;
    ovl_state_t        state_dbg;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    bit mon_en = 1'b0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] ram_mem [1 << ADDR_W];

    typedef struct {
        logic              dl_active;
        logic              dl_wr;
        logic [ADDR_W-1:0] dl_addr;
        logic [DATA_W-1:0] dl_data;
        logic              vid_req;
        logic [ADDR_W-1:0] vid_addr;
        logic              exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wdata;
        logic              exp_vv;
        logic              exp_wait;
        logic              exp_cip;
        logic              exp_rdy;
        logic              exp_ovr;
    } vec_t;

    vec_t tbl [10];

    // ---------------- clock / reset ----------------
    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    overlay_ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .dl_active        (dl_active),
        .dl_wr            (dl_wr),
        .dl_addr          (dl_addr),
        .dl_data          (dl_data),
        .dl_wait          (dl_wait),
        .dl_overrun       (dl_overrun),
        .vid_req          (vid_req),
        .vid_addr         (vid_addr),
        .vid_data         (vid_data),
        .vid_valid        (vid_valid),
        .ram_addr         (ram_addr),
        .ram_we           (ram_we),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata),
        .copy_in_progress (copy_in_progress),
        .overlay_ready    (overlay_ready),
        .state_dbg        (state_dbg)
    );

    // Single-port RAM model, read-before-write, one cycle read latency.
    always @(posedge clk_sys) begin
        if (ram_we === 1'b1) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // ---------------- write scoreboard ----------------
    always @(negedge clk_sys) begin
        if (mon_en && ram_we !== 1'b0) begin
            we_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h we=%b, required no write",
                         ram_addr, ram_wdata, ram_we);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                if ({ram_addr, ram_wdata} !== e) begin
                    errors++;
                    $display("FAIL write_order: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                             ram_addr, ram_wdata, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_bundle();
        return {4'b0, ram_we, ram_addr, ram_wdata, vid_valid, dl_wait,
                copy_in_progress, overlay_ready, dl_overrun};
    endfunction

    function automatic vec_t mk(input logic act, input logic wr, input logic [ADDR_W-1:0] wa,
                                input logic [DATA_W-1:0] wd, input logic vr, input logic [ADDR_W-1:0] va,
                                input logic we, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                                input logic vv, input logic wt, input logic cip, input logic rdy,
                                input logic ovr);
        vec_t v;
        v.dl_active = act; v.dl_wr = wr; v.dl_addr = wa; v.dl_data = wd;
        v.vid_req = vr; v.vid_addr = va;
        v.exp_we = we; v.exp_addr = ea; v.exp_wdata = ed; v.exp_vv = vv;
        v.exp_wait = wt; v.exp_cip = cip; v.exp_rdy = rdy; v.exp_ovr = ovr;
        return v;
    endfunction

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit expect_it);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        if (expect_it) exp_q.push_back({a, d});
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (overlay_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (overlay_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: overlay_ready=%b after %0d cycles, required 1", name, overlay_ready, n);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base;
        logic prev_we;
        int n;

        for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = '0;

        // Reset held 3 edges with request lines toggling.
        reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        vid_req = 1'b0; vid_addr = '0;
        for (int i = 0; i < 3; i++) begin
            dl_wr   = i[0];
            vid_req = ~i[0];
            dl_addr = ADDR_W'(i + 5);
            step();
            mon_en = 1'b1;
            check($sformatf("reset_outputs%0d", i), out_bundle(), 32'h0);
        end
        reset_n = 1'b1; dl_wr = 1'b0; vid_req = 1'b0;
        step();
        check("reset_release_outputs", out_bundle(), 32'h0);
        check("reset_state_idle", 32'(state_dbg), 32'(ST_IDLE));

        // Cycle vector table: short load with an interleaved video read.
        tbl[0] = mk(1, 0, 14'h000, 8'h00, 0, 14'h000,  0, 14'h000, 8'h00, 0, 0, 1, 0, 0);
        tbl[1] = mk(1, 1, 14'h010, 8'h11, 0, 14'h000,  0, 14'h000, 8'h00, 0, 0, 1, 0, 0);
        tbl[2] = mk(1, 1, 14'h020, 8'h22, 1, 14'h300,  0, 14'h300, 8'h00, 0, 0, 1, 0, 0);
        tbl[3] = mk(1, 1, 14'h030, 8'h33, 0, 14'h000,  1, 14'h010, 8'h11, 1, 0, 1, 0, 0);
        tbl[4] = mk(0, 0, 14'h000, 8'h00, 1, 14'h301,  0, 14'h301, 8'h11, 0, 0, 1, 0, 0);
        tbl[5] = mk(0, 0, 14'h000, 8'h00, 0, 14'h000,  1, 14'h020, 8'h22, 1, 0, 1, 0, 0);
        tbl[6] = mk(0, 0, 14'h000, 8'h00, 0, 14'h000,  1, 14'h030, 8'h33, 0, 0, 1, 0, 0);
        tbl[7] = mk(0, 0, 14'h000, 8'h00, 0, 14'h000,  0, 14'h030, 8'h33, 0, 0, 0, 1, 0);
        tbl[8] = mk(0, 1, 14'h03A, 8'h44, 0, 14'h000,  0, 14'h030, 8'h33, 0, 0, 0, 1, 0);
        tbl[9] = mk(0, 0, 14'h000, 8'h00, 0, 14'h000,  0, 14'h030, 8'h33, 0, 0, 0, 1, 0);
        exp_q.push_back({14'h010, 8'h11});
        exp_q.push_back({14'h020, 8'h22});
        exp_q.push_back({14'h030, 8'h33});
        for (int i = 0; i < 10; i++) begin
            dl_active = tbl[i].dl_active; dl_wr = tbl[i].dl_wr;
            dl_addr = tbl[i].dl_addr; dl_data = tbl[i].dl_data;
            vid_req = tbl[i].vid_req; vid_addr = tbl[i].vid_addr;
            step();
            check($sformatf("vec%0d", i), out_bundle(),
                  {4'b0, tbl[i].exp_we, tbl[i].exp_addr, tbl[i].exp_wdata, tbl[i].exp_vv,
                   tbl[i].exp_wait, tbl[i].exp_cip, tbl[i].exp_rdy, tbl[i].exp_ovr});
        end
        dl_wr = 1'b0; vid_req = 1'b0;

        // Clean load of 16 bytes.
        base = we_count;
        dl_active = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            push_wr(ADDR_W'(i), DATA_W'(8'hA0 + i), 1'b1);
            step();
        end
        dl_wr = 1'b0; dl_active = 1'b0;
        prev_we = ram_we; n = 0;
        while (overlay_ready !== 1'b1 && n < 50) begin
            prev_we = ram_we;
            step();
            n++;
        end
        check("load_ready", 32'(overlay_ready), 32'h1);
        check("load_ready_after_last_we", 32'(prev_we), 32'h1);
        check("load_cip_falls", 32'(copy_in_progress), 32'h0);
        step();
        check("load_write_count", 32'(we_count - base), 32'd16);
        check("load_queue_drained", 32'(exp_q.size()), 32'd0);
        check("load_no_overrun", 32'(dl_overrun), 32'h0);

        // Video priority: 20-cycle read hold with 3 writes queued.
        base = we_count;
        dl_active = 1'b1;
        step();
        vid_req = 1'b1; vid_addr = 14'h3FF;
        for (int i = 0; i < 20; i++) begin
            if (i < 3) push_wr(ADDR_W'(14'h100 + i), DATA_W'(8'h50 + i), 1'b1);
            else       dl_wr = 1'b0;
            step();
            check($sformatf("prio_hold_we%0d", i), 32'(ram_we), 32'h0);
            if (i == 1) check("prio_wait_count2", 32'(dl_wait), 32'h0);
            if (i == 2) check("prio_wait_count3", 32'(dl_wait), 32'h1);
        end
        vid_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("prio_drain_we%0d", i), 32'(ram_we), 32'h1);
        end
        step();
        check("prio_drain_done", 32'(ram_we), 32'h0);
        check("prio_write_count", 32'(we_count - base), 32'd3);
        check("prio_wait_cleared", 32'(dl_wait), 32'h0);
        dl_active = 1'b0;
        wait_ready("prio_ready");

        // Overrun: five writes into a four-deep FIFO while video holds the RAM.
        base = we_count;
        dl_active = 1'b1;
        step();
        vid_req = 1'b1; vid_addr = 14'h3FE;
        for (int i = 0; i < 5; i++) begin
            push_wr(ADDR_W'(14'h200 + i), DATA_W'(8'h60 + i), i < 4);
            step();
            if (i == 3) check("ovr_before_drop", 32'(dl_overrun), 32'h0);
            if (i == 3) check("ovr_full_wait", 32'(dl_wait), 32'h1);
            if (i == 4) check("ovr_after_drop", 32'(dl_overrun), 32'h1);
        end
        dl_wr = 1'b0;
        step();
        vid_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("ovr_write_count", 32'(we_count - base), 32'd4);
        check("ovr_queue_drained", 32'(exp_q.size()), 32'd0);
        dl_active = 1'b0;
        wait_ready("ovr_ready");
        check("ovr_sticky", 32'(dl_overrun), 32'h1);

        // Read-back load; the rising dl_active clears the sticky overrun.
        dl_active = 1'b1;
        step();
        check("ovr_cleared_on_load", 32'(dl_overrun), 32'h0);
        push_wr(14'h0123, 8'h5A, 1'b1);
        step();
        dl_wr = 1'b0; dl_active = 1'b0;
        wait_ready("rb_ready");
        step();
        vid_req = 1'b1; vid_addr = 14'h0123;
        step();
        vid_req = 1'b0;
        check("rb_valid_n", 32'(vid_valid), 32'h0);
        step();
        check("rb_valid_n1", 32'(vid_valid), 32'h1);
        check("rb_data", 32'(vid_data), 32'h5A);
        step();
        check("rb_valid_n2", 32'(vid_valid), 32'h0);

        // Back-to-back reads of clean-load bytes 3..5.
        for (int c = 0; c < 5; c++) begin
            vid_req  = (c < 3);
            vid_addr = ADDR_W'(3 + c);
            step();
            if (c >= 1 && c <= 3) begin
                check($sformatf("burst_valid%0d", c), 32'(vid_valid), 32'h1);
                check($sformatf("burst_data%0d", c), 32'(vid_data), 32'(8'hA3 + c - 1));
            end else begin
                check($sformatf("burst_valid%0d", c), 32'(vid_valid), 32'h0);
            end
        end

        // Reset mid-load with two entries queued behind a video hold.
        dl_active = 1'b1;
        step();
        vid_req = 1'b1; vid_addr = 14'h3FD;
        push_wr(14'h3F0, 8'h71, 1'b0);
        step();
        push_wr(14'h3F1, 8'h72, 1'b0);
        step();
        dl_wr = 1'b0;
        check("midreset_queued_wait", 32'(dl_wait), 32'h0);
        reset_n = 1'b0; dl_active = 1'b0;
        step();
        check("midreset_outputs", out_bundle(), 32'h0);
        check("midreset_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        reset_n = 1'b1; vid_req = 1'b0;
        base = we_count;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("midreset_no_we%0d", i), 32'(ram_we), 32'h0);
        end
        check("midreset_write_count", 32'(we_count - base), 32'd0);
        check("midreset_idle_after", 32'(state_dbg), 32'(ST_IDLE));
        check("midreset_cip", 32'(copy_in_progress), 32'h0);
        check("midreset_ready", 32'(overlay_ready), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/overlay_ram_arbiter.md
# overlay_ram_arbiter

Shares the single-port overlay RAM of the cassette overlay core between two requesters: HPS download writes (ioctl side) and video scanout reads from the soc display path. Download writes pass through a small write FIFO with backpressure. Video reads have absolute priority. A load sequencer tracks download/flush progress and drives `copy_in_progress` (wired to LED_USER) and `overlay_ready`.

## Interface
Parameters:
- ADDR_W, 14, overlay RAM address width
- DATA_W, 8, overlay RAM data width
- FIFO_DEPTH, 4, write FIFO entries (power of two, ≥2)

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- dl_active  in  1  HPS download in progress (level)
- dl_wr  in  1  download write strobe, one byte per cycle high
- dl_addr  in  ADDR_W  download byte address
- dl_data  in  DATA_W  download byte
- dl_wait  out  1  backpressure to HPS
- dl_overrun  out  1  sticky: a write was dropped
- vid_req  in  1  video read request
- vid_addr  in  ADDR_W  video read address
- vid_data  out  DATA_W  read data (= ram_rdata)
- vid_valid  out  1  vid_data valid this cycle
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency
- copy_in_progress  out  1  load or flush underway
- overlay_ready  out  1  complete image resident in RAM

## Operation
- Load sequencer states: IDLE, LOADING, FLUSH, READY.
- IDLE/READY → LOADING on rising edge of dl_active (registered compare). On entry: clear overlay_ready, clear dl_overrun.
- LOADING → FLUSH on falling edge of dl_active.
- FLUSH → READY when FIFO empty and no write issued this cycle.
- LOADING → LOADING if dl_active falls and rises within one cycle is not possible; edge detect on a single registered copy.
- copy_in_progress = (LOADING | FLUSH). overlay_ready = READY.
- FIFO push: dl_wr in LOADING only; dl_wr in any other state ignored.
- Push while FIFO full and no pop that cycle: drop, set dl_overrun.
- Push while full with a simultaneous pop: accept.
- dl_wait = (count ≥ FIFO_DEPTH−1).
- Arbitration each cycle: vid_req=1 → issue read of vid_addr (ram_we=0). Otherwise, if FIFO non-empty → pop and issue write (ram_we=1, addr/data from head).
- Video never stalled. Writes drain only in cycles with vid_req=0. No starvation guard: HPS must honour dl_wait.
- FIFO preserves order. A write and a later read to the same address: the write lands first only if it was popped earlier. Readers must wait for overlay_ready for coherent data.
- RAM contents are not cleared by reset or by a new load.

## Timing
- Reset (reset_n low at edge): state IDLE, FIFO empty. Outputs dl_wait, dl_overrun, vid_valid, ram_we, copy_in_progress, overlay_ready, ram_addr, ram_wdata all 0.
- Reset mid-load discards queued entries; no ram_we after the reset edge.
- vid_req sampled at edge N: ram_addr driven during cycle N+1, ram_rdata/vid_data valid cycle N+2, vid_valid=1 in cycle N+2. Fixed 2-cycle latency, fully pipelined, one read per cycle.
- dl_wr sampled at edge N with empty FIFO and vid_req=0 at N+1: ram_we high in cycle N+2.
- dl_wait updates the cycle after the count change.
- FLUSH→READY: overlay_ready rises and copy_in_progress falls in the same cycle, one cycle after the final ram_we.

## Structure
- Package `overlay_pkg`: state enum `ovl_state_t` (IDLE, LOADING, FLUSH, READY) and the default FIFO_DEPTH constant.
- Sub-module `overlay_wr_fifo`: synchronous FIFO of {addr,data}. Provides count, full, empty, push, and pop; push and pop in the same cycle are legal.
- Top holds edge detect, sequencer, arbiter mux, and output registers.

## Test plan
- Reset: hold reset_n low 3 cycles with dl_wr/vid_req toggling → all outputs 0, no ram_we.
- Clean load: dl_active high, 16 writes addr 0..15 data 0xA0+i, vid_req=0, dl_active low → 16 ram_we in order with matching addr/data. overlay_ready=1 one cycle after the last write; copy_in_progress falls in that same cycle.
- Video priority: vid_req held 20 cycles while 3 writes pushed → zero ram_we during the hold, dl_wait=1 once count=3. All 3 writes drain in the 3 cycles after vid_req drops.
- Overrun: vid_req held, 5 consecutive dl_wr ignoring dl_wait → 5th dropped, dl_overrun=1. Only entries 1–4 written afterwards; dl_overrun clears on the next dl_active rise.
- Read-back: write 0x5A to 0x0123, wait for overlay_ready, single vid_req at 0x0123 → vid_valid exactly 2 cycles later with vid_data=0x5A.
- Reset mid-load: 2 entries queued, reset_n low one edge → no further ram_we, copy_in_progress=0, overlay_ready=0, state IDLE.
